// File: rtl/vdp99_cpu_port.sv
// Z80-side I/O responder for the VDP99: data/control ports, R0-R7, VRAM address
// counter with read-ahead buffer, status/IRQ. Define VDP99_CPU_PORT_WAIT_EN to add wait_n.
module vdp99_cpu_port #(
    parameter logic [6:0] BASE_ADDR = 7'h40,
    parameter int          VRAM_AW   = 14
) (
    input  logic               phi,
    input  logic               reset_n,
    input  logic               iorq,
    input  logic               rd,
    input  logic               wr,
    input  logic [7:0]         a,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic               dout_oe,
    output logic               irq,
    output logic [63:0]        regs,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    output logic               vram_we,
    output logic               vram_req,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rdata,
    input  logic               frame_int,
    input  logic               spr_coll,
    input  logic               spr_5th,
    input  logic [4:0]         spr_5th_num
`ifdef VDP99_CPU_PORT_WAIT_EN
    ,
    output logic               wait_n
`endif
);

    logic               sel, busy, hold;
    logic               wsel, rsel, w_rise, r_rise, r_fall;
    logic               wsel_q, rsel_q;
    logic [7:0][7:0]    regs_q, regs_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [VRAM_AW-1:0] vaddr_q, vaddr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               req_q, req_d;
    logic               pend_q, pend_d;
    logic [7:0]         buf_q, buf_d;
    logic [7:0]         tmp_q, tmp_d;
    logic               flag_q, flag_d;
    logic [7:0]         dout_q, dout_d;
    logic               oe_q, oe_d;
    logic               rkind_q, rkind_d;
    logic               rdrop_q, rdrop_d;
    logic               f_q, f_d, s5_q, s5_d, c_q, c_d;
    logic [4:0]         num_q, num_d;

    assign sel  = iorq & (a[7:1] == BASE_ADDR);
    // A queued read-ahead counts as busy so a data access cannot slip in ahead of it.
    assign busy = req_q | pend_q;

`ifdef VDP99_CPU_PORT_WAIT_EN
    assign hold   = sel & ~a[0] & busy;
    assign wait_n = ~hold;
`else
    assign hold   = 1'b0;
`endif

    assign wsel   = sel & wr & ~hold;
    assign rsel   = sel & rd & ~hold;
    assign w_rise = wsel & ~wsel_q;
    assign r_rise = rsel & ~rsel_q;
    assign r_fall = ~rsel & rsel_q;

    always_comb begin
        regs_d  = regs_q;
        addr_d  = addr_q;
        vaddr_d = vaddr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        req_d   = req_q;
        pend_d  = pend_q;
        buf_d   = buf_q;
        tmp_d   = tmp_q;
        flag_d  = flag_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        rkind_d = rkind_q;
        rdrop_d = rdrop_q;
        f_d     = f_q;
        s5_d    = s5_q;
        c_d     = c_q;
        num_d   = num_q;

        if (req_q && vram_ack) begin
            req_d = 1'b0;
            if (!we_q) buf_d = vram_rdata;
        end

        if (pend_q && !req_q) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            vaddr_d = addr_q;
            addr_d  = addr_q + VRAM_AW'(1);
            pend_d  = 1'b0;
        end

        if (w_rise) begin
            if (!a[0]) begin
                if (!busy) begin
                    flag_d  = 1'b0;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    vaddr_d = addr_q;
                    wdata_d = din;
                    addr_d  = addr_q + VRAM_AW'(1);
                end
            end else if (!flag_q) begin
                tmp_d  = din;
                flag_d = 1'b1;
            end else begin
                flag_d = 1'b0;
                if (din[7]) begin
                    regs_d[din[2:0]] = tmp_q;
                end else begin
                    addr_d = VRAM_AW'({din[5:0], tmp_q});
                    if (!din[6]) pend_d = 1'b1;
                end
            end
        end

        if (r_rise) begin
            rkind_d = a[0];
            rdrop_d = ~a[0] & busy;
            dout_d  = a[0] ? {f_q, s5_q, c_q, num_q} : buf_q;
            oe_d    = 1'b1;
        end

        if (r_fall) begin
            oe_d = 1'b0;
            if (rkind_q) begin
                f_d    = 1'b0;
                s5_d   = 1'b0;
                c_d    = 1'b0;
                flag_d = 1'b0;
            end else if (!rdrop_q) begin
                flag_d = 1'b0;
                pend_d = 1'b1;
            end
        end

        // Status sets come last so a set pulse beats a same-phi clear.
        if (frame_int) f_d = 1'b1;
        if (spr_coll)  c_d = 1'b1;
        if (spr_5th) begin
            if (!s5_q) num_d = spr_5th_num;
            s5_d = 1'b1;
        end
    end

    always_ff @(posedge phi or negedge reset_n) begin
        if (!reset_n) begin
            wsel_q  <= 1'b0;
            rsel_q  <= 1'b0;
            regs_q  <= '0;
            addr_q  <= '0;
            vaddr_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            pend_q  <= 1'b0;
            buf_q   <= '0;
            tmp_q   <= '0;
            flag_q  <= 1'b0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            rkind_q <= 1'b0;
            rdrop_q <= 1'b0;
            f_q     <= 1'b0;
            s5_q    <= 1'b0;
            c_q     <= 1'b0;
            num_q   <= '0;
        end else begin
            wsel_q  <= wsel;
            rsel_q  <= rsel;
            regs_q  <= regs_d;
            addr_q  <= addr_d;
            vaddr_q <= vaddr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            tmp_q   <= tmp_d;
            flag_q  <= flag_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            rkind_q <= rkind_d;
            rdrop_q <= rdrop_d;
            f_q     <= f_d;
            s5_q    <= s5_d;
            c_q     <= c_d;
            num_q   <= num_d;
        end
    end

    assign dout       = dout_q;
    assign dout_oe    = oe_q & rsel;
    assign irq        = f_q & regs_q[1][5];
    assign regs       = regs_q;
    assign vram_addr  = vaddr_q;
    assign vram_wdata = wdata_q;
    assign vram_we    = we_q;
    assign vram_req   = req_q;

endmodule

// File: tb/tb_vdp99_cpu_port.sv
// Directed bench for vdp99_cpu_port with a small VRAM responder model.
module tb_vdp99_cpu_port;

    logic        phi = 1'b0;
    logic        reset_n = 1'b0;
    logic        iorq = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [7:0]  a = 8'h00, din = 8'h00;
    logic [7:0]  dout;
    logic        dout_oe, irq;
    logic [63:0] regs;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we, vram_req;
    logic        vram_ack = 1'b0;
    logic [7:0]  vram_rdata = 8'h00;
    logic        frame_int = 1'b0, spr_coll = 1'b0, spr_5th = 1'b0;
    logic [4:0]  spr_5th_num = 5'd0;
`ifdef VDP99_CPU_PORT_WAIT_EN
    logic        wait_n;
`endif

    int n_chk = 0;
    int n_fail = 0;

    vdp99_cpu_port dut (
        .phi(phi), .reset_n(reset_n), .iorq(iorq), .rd(rd), .wr(wr), .a(a), .din(din),
        .dout(dout), .dout_oe(dout_oe), .irq(irq), .regs(regs),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
        .vram_req(vram_req), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .frame_int(frame_int), .spr_coll(spr_coll), .spr_5th(spr_5th),
        .spr_5th_num(spr_5th_num)
`ifdef VDP99_CPU_PORT_WAIT_EN
        ,
        .wait_n(wait_n)
`endif
    );

    always #5 phi = ~phi;

    // VRAM responder: acks on the 3rd phi a request is seen, unless held.
    logic [7:0]  mem [16384];
    logic        hold_ack = 1'b0;
    int          cnt = 0;
    logic [13:0] waddr_q[$];
    logic [7:0]  wdata_q[$];
    logic [13:0] raddr_q[$];

    always @(posedge phi) begin
        vram_ack <= 1'b0;
        if (!vram_req || vram_ack) cnt <= 0;
        else if (!hold_ack) begin
            if (cnt >= 2) begin
                vram_ack <= 1'b1;
                cnt <= 0;
                if (vram_we) begin
                    mem[vram_addr] <= vram_wdata;
                    waddr_q.push_back(vram_addr);
                    wdata_q.push_back(vram_wdata);
                end else begin
                    vram_rdata <= mem[vram_addr];
                    raddr_q.push_back(vram_addr);
                end
            end else cnt <= cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic io(input logic [7:0] addr, input logic [7:0] data, input logic is_rd,
                      output logic [7:0] d_mid, output logic oe_mid);
        a = addr; din = data; iorq = 1'b1;
        if (is_rd) rd = 1'b1; else wr = 1'b1;
        @(posedge phi); #1;
`ifdef VDP99_CPU_PORT_WAIT_EN
        begin
            int wc = 0;
            while (wait_n === 1'b0 && wc < 100) begin
                @(posedge phi); #1;
                wc++;
            end
            if (wc >= 100) chk("wait_bound", wait_n, 1);
        end
`endif
        @(posedge phi); #1;
        d_mid = dout; oe_mid = dout_oe;
        @(posedge phi); #1;
        iorq = 1'b0; rd = 1'b0; wr = 1'b0;
        repeat (6) @(posedge phi);
        #1;
    endtask

    task automatic cw(input logic [7:0] data);
        logic [7:0] d; logic o;
        io(8'h81, data, 1'b0, d, o);
    endtask

    task automatic dw(input logic [7:0] data);
        logic [7:0] d; logic o;
        io(8'h80, data, 1'b0, d, o);
    endtask

    task automatic pulse(input logic f, input logic c, input logic s, input logic [4:0] n);
        frame_int = f; spr_coll = c; spr_5th = s; spr_5th_num = n;
        @(posedge phi); #1;
        frame_int = 1'b0; spr_coll = 1'b0; spr_5th = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       o;

        repeat (2) @(posedge phi);
        #1;
        chk("rst_dout", dout, 8'h00);
        chk("rst_dout_oe", dout_oe, 1'b0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_regs", regs, 64'h0);
        chk("rst_req", vram_req, 1'b0);
        chk("rst_we", vram_we, 1'b0);
        chk("rst_addr", vram_addr, 14'h0);
        chk("rst_wdata", vram_wdata, 8'h00);
        reset_n = 1'b1;
        @(posedge phi); #1;

        // R1 <= 0x60
        cw(8'h60); cw(8'h81);
        chk("r1_write", regs, 64'h0000_0000_0000_6000);
        chk("irq_before_frame", irq, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 5'd0);
        chk("irq_after_frame", irq, 1'b1);
        io(8'h81, 8'h00, 1'b1, d, o);
        chk("status_F", d, 8'h80);
        chk("status_oe", o, 1'b1);
        chk("irq_cleared", irq, 1'b0);
        chk("oe_after_rd", dout_oe, 1'b0);

        // frame_int coinciding with the status clear must keep F set
        a = 8'h81; iorq = 1'b1; rd = 1'b1;
        repeat (3) @(posedge phi);
        #1;
        iorq = 1'b0; rd = 1'b0; frame_int = 1'b1;
        @(posedge phi); #1;
        frame_int = 1'b0;
        repeat (2) @(posedge phi);
        #1;
        chk("set_wins_irq", irq, 1'b1);
        io(8'h81, 8'h00, 1'b1, d, o);
        chk("set_wins_status", d, 8'h80);
        chk("irq_cleared2", irq, 1'b0);

        // VRAM writes at 0x0800..0x0802
        cw(8'h00); cw(8'h48);
        chk("no_req_on_01", vram_req, 1'b0);
        dw(8'hAA); dw(8'h55); dw(8'h77);
        chk("wr_count", waddr_q.size(), 3);
        chk("wr0_addr", waddr_q[0], 14'h0800);
        chk("wr0_data", wdata_q[0], 8'hAA);
        chk("wr1_addr", waddr_q[1], 14'h0801);
        chk("wr1_data", wdata_q[1], 8'h55);
        chk("wr2_addr", waddr_q[2], 14'h0802);

        // read-ahead path
        cw(8'h00); cw(8'h48); dw(8'h5A);
        chk("wr3_addr", waddr_q[3], 14'h0800);
        cw(8'h00); cw(8'h08);
        chk("ra0_addr", raddr_q[0], 14'h0800);
        io(8'h80, 8'h00, 1'b1, d, o);
        chk("rd0_dout", d, 8'h5A);
        chk("rd0_oe", o, 1'b1);
        chk("ra1_addr", raddr_q[1], 14'h0801);
        io(8'h80, 8'h00, 1'b1, d, o);
        chk("rd1_dout", d, 8'h55);
        chk("ra2_addr", raddr_q[2], 14'h0802);

        // sprite status bits and 5th number retention
        pulse(1'b0, 1'b1, 1'b1, 5'd7);
        io(8'h81, 8'h00, 1'b1, d, o);
        chk("status_5s_c", d, 8'h67);
        io(8'h81, 8'h00, 1'b1, d, o);
        chk("status_num_kept", d, 8'h07);
        pulse(1'b0, 1'b0, 1'b1, 5'd9);
        pulse(1'b0, 1'b0, 1'b1, 5'd3);
        io(8'h81, 8'h00, 1'b1, d, o);
        chk("status_num_latch_once", d, 8'h49);

        // status read resets the byte flag
        cw(8'h12);
        io(8'h81, 8'h00, 1'b1, d, o);
        cw(8'h34); cw(8'h83);
        chk("flag_reset_r3", regs, 64'h0000_0000_3400_6000);

        // busy collision on the data port
        cw(8'h00); cw(8'h50);
        hold_ack = 1'b1;
        dw(8'h11);
        chk("held_req", vram_req, 1'b1);
        fork
            begin
                repeat (5) @(posedge phi);
                #2;
                chk("held_addr", vram_addr, 14'h1000);
                chk("held_wdata", vram_wdata, 8'h11);
`ifdef VDP99_CPU_PORT_WAIT_EN
                chk("wait_n_low", wait_n, 1'b0);
`endif
                repeat (5) @(posedge phi);
                #2;
                hold_ack = 1'b0;
            end
            dw(8'h22);
        join
        repeat (8) @(posedge phi);
        #1;
        dw(8'h33);
        chk("coll_first_addr", waddr_q[4], 14'h1000);
        chk("coll_first_data", wdata_q[4], 8'h11);
`ifdef VDP99_CPU_PORT_WAIT_EN
        chk("coll_count", waddr_q.size(), 7);
        chk("coll_defer_addr", waddr_q[5], 14'h1001);
        chk("coll_defer_data", wdata_q[5], 8'h22);
        chk("coll_next_addr", waddr_q[6], 14'h1002);
        chk("coll_next_data", wdata_q[6], 8'h33);
`else
        chk("coll_count", waddr_q.size(), 6);
        chk("coll_next_addr", waddr_q[5], 14'h1001);
        chk("coll_next_data", wdata_q[5], 8'h33);
`endif

        // reset mid-access aborts the request and the byte flag
        hold_ack = 1'b1;
        dw(8'h99);
        cw(8'h12);
        chk("pre_reset_req", vram_req, 1'b1);
        reset_n = 1'b0;
        #2;
        chk("reset_req_drop", vram_req, 1'b0);
        chk("reset_regs", regs, 64'h0);
        @(posedge phi); #1;
        reset_n = 1'b1;
        hold_ack = 1'b0;
        @(posedge phi); #1;
        cw(8'h34); cw(8'h84);
        chk("reset_flag_r4", regs, 64'h0000_0034_0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
